// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial, LSB-first subtractor computing X - Y - BIN.
// One 1-bit full-subtractor cell is reused for WIDTH cycles. The borrow is
// chained through a register and the difference bits are collected in a
// shift register.
// Optional feature: define SERIAL_SUB_OVERFLOW_EN to add the signed-overflow
// output V.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             BIN,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] D,
  output logic             B
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic             V
`endif
);

  // The counter has one spare bit, so it can reach WIDTH without wrapping.
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] x_reg, y_reg, res_reg;
  logic [WIDTH-1:0] res_next;
  logic             borrow_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] d_reg;
  logic             b_reg;
  logic             x_bit, y_bit, d_bit, b_next, last_bit;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             v_reg;
  logic             v_next;
`endif

  // Full-subtractor cell applied to the current LSBs of the shifting operands.
  always_comb begin
    x_bit    = x_reg[0];
    y_bit    = y_reg[0];
    d_bit    = x_bit ^ y_bit ^ borrow_reg;
    b_next   = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & borrow_reg);
    // The new difference bit enters at the MSB. After WIDTH shifts, bit 0
    // of the result holds the first bit that was computed.
    res_next = (res_reg >> 1) | {d_bit, {(WIDTH-1){1'b0}}};
    last_bit = (cnt_reg == LAST_BIT);
`ifdef SERIAL_SUB_OVERFLOW_EN
    // On the last bit, x_bit and y_bit are the original operand MSBs and
    // d_bit is the result MSB.
    v_next   = (x_bit ^ y_bit) & (d_bit ^ x_bit);
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_next = state_reg;
    ready      = 1'b0;
    valid      = 1'b0;
    case (state_reg)
      IDLE: begin
        ready = 1'b1;
        if (start) state_next = RUN;
      end
      RUN: begin
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        valid      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latch the operands on accept, shift one bit per RUN cycle, and
  // publish the results only on the final bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_reg      <= '0;
      y_reg      <= '0;
      res_reg    <= '0;
      borrow_reg <= 1'b0;
      cnt_reg    <= '0;
      d_reg      <= '0;
      b_reg      <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      v_reg      <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            x_reg      <= X;
            y_reg      <= Y;
            borrow_reg <= BIN;
            res_reg    <= '0;
            cnt_reg    <= '0;
          end
        end
        RUN: begin
          x_reg      <= x_reg >> 1;
          y_reg      <= y_reg >> 1;
          borrow_reg <= b_next;
          res_reg    <= res_next;
          cnt_reg    <= cnt_reg + CNT_ONE;
          if (last_bit) begin
            d_reg <= res_next;
            b_reg <= b_next;
`ifdef SERIAL_SUB_OVERFLOW_EN
            v_reg <= v_next;
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign D = d_reg;
  assign B = b_reg;
`ifdef SERIAL_SUB_OVERFLOW_EN
  assign V = v_reg;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard testbench for serial_subtractor (WIDTH=8).
// The stimulus process pushes the expected results, computed with plain
// integer arithmetic. The monitor process pops and compares them whenever
// valid is high.
module tb_serial_subtractor;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] X, Y;
  logic         BIN;
  logic         ready, valid;
  logic [W-1:0] D;
  logic         B;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic         V;
`endif

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .X(X), .Y(Y), .BIN(BIN),
    .ready(ready), .valid(valid), .D(D), .B(B)
`ifdef SERIAL_SUB_OVERFLOW_EN
    , .V(V)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] d;
    logic         b;
    logic         v;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: unsigned and signed integer subtraction.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic bin, input int acc);
    exp_t e;
    int   ud, sd;
    ud = int'(x) - int'(y) - int'(bin);
    sd = int'($signed(x)) - int'($signed(y)) - int'(bin);
    e.d   = W'(ud);
    e.b   = (ud < 0);
    e.v   = (sd < -(1 << (W-1))) || (sd > (1 << (W-1)) - 1);
    e.acc = acc;
    return e;
  endfunction

  // Monitor: score every result, check the one-cycle strobe, and check that
  // D and B hold their values between results.
  exp_t         mon_e;
  logic [W-1:0] prev_d;
  logic         prev_b;
  logic         prev_valid = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_d     = D;
      prev_b     = B;
      prev_valid = 1'b0;
    end else begin
      if (valid) begin
        chk("valid_single_cycle", 32'(prev_valid), 32'd0);
        chk("ready_low_in_done", 32'(ready), 32'd0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got D=%0h B=%0b expected no result", D, B);
        end else begin
          mon_e = sb.pop_front();
          $display("result: D=%02h B=%0b latency=%0d", D, B, cyc - mon_e.acc);
          chk("D", 32'(D), 32'(mon_e.d));
          chk("B", 32'(B), 32'(mon_e.b));
`ifdef SERIAL_SUB_OVERFLOW_EN
          chk("V", 32'(V), 32'(mon_e.v));
`endif
          chk("latency", 32'(cyc - mon_e.acc), 32'(W));
        end
      end else begin
        chk("hold_D", 32'(D), 32'(prev_d));
        chk("hold_B", 32'(B), 32'(prev_b));
      end
      prev_d     = D;
      prev_b     = B;
      prev_valid = valid;
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(ready), 32'd1);
  endtask

  // Issue one operation. If expect_it is set, the expected result goes to
  // the scoreboard. Afterwards the inputs are scrambled so that any
  // late sampling of X, Y or BIN is caught.
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic bin, input bit expect_it);
    wait_ready();
    X = x; Y = y; BIN = bin; start = 1'b1;
    if (expect_it) sb.push_back(model(x, y, bin, cyc + 1));
    $display("issue: X=%02h Y=%02h BIN=%0b", x, y, bin);
    @(posedge clk);
    #1;
    start = 1'b0;
    X = W'($urandom); Y = W'($urandom); BIN = 1'($urandom);
    @(negedge clk);
    chk("ready_low_in_run", 32'(ready), 32'd0);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(ready), 32'd1);
    chk({tag, "_valid"}, 32'(valid), 32'd0);
    chk({tag, "_D"}, 32'(D), 32'd0);
    chk({tag, "_B"}, 32'(B), 32'd0);
`ifdef SERIAL_SUB_OVERFLOW_EN
    chk({tag, "_V"}, 32'(V), 32'd0);
`endif
  endtask

  // Stimulus.
  initial begin
    rst = 1'b1; start = 1'b0; X = '0; Y = '0; BIN = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Directed cases.
    issue(8'h05, 8'h03, 1'b0, 1'b1);
    issue(8'h03, 8'h05, 1'b0, 1'b1);
    issue(8'h00, 8'h00, 1'b1, 1'b1);
    issue(8'hFF, 8'hFF, 1'b1, 1'b1);
    issue(8'h80, 8'h01, 1'b0, 1'b1);
    issue(8'h7F, 8'hFF, 1'b0, 1'b1);
    issue(8'h00, 8'hFF, 1'b1, 1'b1);
    wait_drain();

    // A start pulse during RUN is ignored.
    issue(8'h10, 8'h01, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    X = 8'hAA; Y = 8'h55; BIN = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_drain();
    @(negedge clk);
    chk("ready_after_done", 32'(ready), 32'd1);

    // A reset during RUN aborts the operation with no result.
    issue(8'h9C, 8'h21, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    check_reset_outputs("abort");
    rst = 1'b0;
    issue(8'h9C, 8'h21, 1'b1, 1'b1);
    wait_drain();

    // Random operations, some issued back-to-back.
    for (int i = 0; i < 40; i++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom), 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_drain();
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
